bcd_count_ctrl: RTL and testbench

- Controller and sequencer for a cascade of DIGITS mod-10 (BCD) digit counters.
- Generates the count-enable tick from a clock prescaler and runs a start/stop/clear/load state machine.
- Propagates carry/borrow between digits and flags full-range wrap-around.
- Feeds display/stopwatch logic downstream.

---
 rtl/bcd_count_ctrl_if.sv | 41 ++++
 rtl/bcd_count_ctrl.sv | 156 +++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_count_ctrl_if.sv
// Command/status bundle between a BCD counter controller and its client.
// Latency: none, wires only.
// Backpressure: none; commands are levels sampled every clock.
// LAP_CAPTURE_EN adds the lap strobe and captured lap value.
interface bcd_count_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                start;
    logic                stop;
    logic                clear;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic                up_dn;
    logic [4*DIGITS-1:0] count;
    logic                tick;
    logic                wrap;
    logic                running;
    logic [1:0]          state;
`ifdef LAP_CAPTURE_EN
    logic                lap;
    logic [4*DIGITS-1:0] lap_count;

    modport master (
        output start, stop, clear, load, load_val, up_dn, lap,
        input  count, tick, wrap, running, state, lap_count
    );
    modport slave (
        input  start, stop, clear, load, load_val, up_dn, lap,
        output count, tick, wrap, running, state, lap_count
    );
`else
    modport master (
        output start, stop, clear, load, load_val, up_dn,
        input  count, tick, wrap, running, state
    );
    modport slave (
        input  start, stop, clear, load, load_val, up_dn,
        output count, tick, wrap, running, state
    );
`endif
endinterface

// File: rtl/bcd_count_ctrl.sv
// Prescaled start/stop/clear/load sequencer for a cascade of BCD digit counters.
// Latency: commands act on the next edge; a step is visible one cycle after the prescaler terminal edge.
// Backpressure: none; level commands, priority clear > load > stop > start. Optional: LAP_CAPTURE_EN.
module bcd_count_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic            clk,
    input  logic            Reset,
    bcd_count_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          running_q;

    logic [W-1:0]  step_val;
    logic          step_carry;
    logic [W-1:0]  load_clean;

    // Next count for one step in the requested direction; carry out of the top digit means full-range wrap.
    always_comb begin
        step_val   = count_q;
        step_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_carry) begin
                if (bus.up_dn) begin
                    if (count_q[4*i +: 4] >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        step_carry         = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        step_carry         = 1'b0;
                    end
                end
            end
        end
    end

    // Non-decimal preset digits load as zero so the count can never leave BCD range.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = bus.load_val[4*i +: 4];
            end
        end
    end

    // Command decode, prescaler advance and counting step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
            presc_d = '0;
        end else if (bus.load && (state_q != RUN)) begin
            count_d = load_clean;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                PAUSE: begin
                    // Resume keeps the partially elapsed prescale interval.
                    if (bus.start && !bus.stop) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PTOP) begin
                        presc_d = '0;
                        count_d = step_val;
                        tick_d  = 1'b1;
                        wrap_d  = step_carry;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register; running is registered from the next state so it always matches state.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == RUN);
        end
    end

    assign bus.count   = count_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.running = running_q;
    assign bus.state   = state_q;

`ifdef LAP_CAPTURE_EN
    logic [W-1:0] lap_q;

    // Lap snapshot of the value visible this cycle, taken only while running.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            lap_q <= '0;
        end else if (bus.clear) begin
            lap_q <= '0;
        end else if (bus.lap && (state_q == RUN)) begin
            lap_q <= count_q;
        end
    end

    assign bus.lap_count = lap_q;
`endif
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with DIGITS=4, PRESCALE=4.
// Expected step results come from a decimal-arithmetic model queued per step.
// Outputs sampled 1 time unit after each rising edge.
module tb_bcd_count_ctrl;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;

    typedef struct packed {
        logic        w;
        logic [15:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    bcd_count_ctrl_if #(.DIGITS(DIGITS)) bif();

    bcd_count_ctrl #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bif)
    );

    int          vectors = 0;
    int          errs    = 0;
    exp_t        sbq[$];
    logic [15:0] mdl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference step computed through plain integer arithmetic.
    function automatic exp_t model_step(input logic [15:0] v, input logic up);
        int   x;
        exp_t r;
        x = 0;
        for (int i = 3; i >= 0; i--) x = x * 10 + int'(v[4*i +: 4]);
        if (up) begin
            r.w = (x == 9999);
            x   = (x + 1) % 10000;
        end else begin
            r.w = (x == 0);
            x   = (x + 9999) % 10000;
        end
        r.v = '0;
        for (int i = 0; i < 4; i++) begin
            r.v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Queue the expected step, wait (bounded) for tick, then compare value, wrap and delay.
    task automatic step_check(input string tag, input int exp_cyc);
        exp_t e;
        int   n;
        logic seen;
        e   = model_step(mdl, bif.up_dn);
        mdl = e.v;
        sbq.push_back(e);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            cyc();
            n++;
            if (bif.tick === 1'b1) seen = 1'b1;
        end
        chk({tag, "_tick"}, 32'(seen), 32'd1);
        e = sbq.pop_front();
        if (seen) begin
            chk({tag, "_count"}, 32'(bif.count), 32'(e.v));
            chk({tag, "_wrap"}, 32'(bif.wrap), 32'(e.w));
            if (exp_cyc >= 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bif.load_val = v;
        bif.load     = 1'b1;
        cyc();
        bif.load     = 1'b0;
    endtask

    task automatic do_start();
        bif.start = 1'b1;
        cyc();
        bif.start = 1'b0;
    endtask

    task automatic do_stop();
        bif.stop = 1'b1;
        cyc();
        bif.stop = 1'b0;
    endtask

    task automatic do_clear();
        bif.clear = 1'b1;
        cyc();
        bif.clear = 1'b0;
        mdl = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b0;
        bif.start    = 1'b0;
        bif.stop     = 1'b0;
        bif.clear    = 1'b0;
        bif.load     = 1'b0;
        bif.load_val = '0;
        bif.up_dn    = 1'b1;
`ifdef LAP_CAPTURE_EN
        bif.lap      = 1'b0;
`endif
        mdl = '0;
        cyc();
        cyc();
        chk("rst_count", 32'(bif.count), 32'h0);
        chk("rst_state", 32'(bif.state), 32'h0);
        chk("rst_running", 32'(bif.running), 32'h0);
        chk("rst_tick", 32'(bif.tick), 32'h0);
        chk("rst_wrap", 32'(bif.wrap), 32'h0);
        Reset = 1'b1;
        cyc();

        // Reset asserted mid-run
        do_load(16'h0123);
        chk("pre_load", 32'(bif.count), 32'h0123);
        do_start();
        chk("run_state", 32'(bif.state), 32'h1);
        chk("run_running", 32'(bif.running), 32'h1);
        cyc();
        cyc();
        Reset = 1'b0;
        #1;
        chk("async_count", 32'(bif.count), 32'h0);
        chk("async_state", 32'(bif.state), 32'h0);
        chk("async_running", 32'(bif.running), 32'h0);
        chk("async_tick", 32'(bif.tick), 32'h0);
        cyc();
        cyc();
        chk("rst_hold", 32'(bif.count), 32'h0);
        Reset = 1'b1;
        cyc();
        mdl = '0;
        do_start();
        step_check("first", 4);
        cyc();
        chk("tick_pulse", 32'(bif.tick), 32'h0);
        do_clear();
        chk("clr_state", 32'(bif.state), 32'h0);
        chk("clr_count", 32'(bif.count), 32'h0);

        // Up carries and full-range wrap
        bif.up_dn = 1'b1;
        do_load(16'h0998);
        mdl = 16'h0998;
        do_start();
        step_check("up0999", 4);
        step_check("up1000", 4);
        do_stop();
        do_load(16'h9999);
        mdl = 16'h9999;
        do_start();
        step_check("upwrap", 4);
        cyc();
        chk("wrap_once", 32'(bif.wrap), 32'h0);
        chk("wrap_tick_once", 32'(bif.tick), 32'h0);

        // Down borrows and full-range wrap
        do_stop();
        do_load(16'h1000);
        mdl = 16'h1000;
        bif.up_dn = 1'b0;
        do_start();
        step_check("dn0999", 4);
        do_stop();
        do_load(16'h0000);
        mdl = 16'h0000;
        do_start();
        step_check("dnwrap", 4);
        do_clear();

        // Pause holds count and prescaler, resume continues the interval
        bif.up_dn = 1'b1;
        do_load(16'h0004);
        mdl = 16'h0004;
        do_start();
        step_check("run5", 4);
        cyc();
        cyc();
        do_stop();
        chk("pause_state", 32'(bif.state), 32'h2);
        chk("pause_running", 32'(bif.running), 32'h0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("pause_hold", 32'(bif.count), 32'(mdl));
        end
        do_start();
        step_check("resume", 2);
        bif.stop  = 1'b1;
        bif.start = 1'b1;
        cyc();
        bif.stop  = 1'b0;
        bif.start = 1'b0;
        chk("stopstart_state", 32'(bif.state), 32'h2);
        chk("stopstart_running", 32'(bif.running), 32'h0);

        // Load while running is ignored; clear beats load
        do_start();
        do_load(16'h4321);
        chk("runload_count", 32'(bif.count), 32'(mdl));
        chk("runload_state", 32'(bif.state), 32'h1);
        do_stop();
        bif.load_val = 16'h4321;
        bif.load     = 1'b1;
        bif.clear    = 1'b1;
        cyc();
        bif.load     = 1'b0;
        bif.clear    = 1'b0;
        mdl = '0;
        chk("clrload_count", 32'(bif.count), 32'h0);
        chk("clrload_state", 32'(bif.state), 32'h0);
        do_load(16'h00AF);
        chk("load_bad", 32'(bif.count), 32'h0);
        do_load(16'h12A5);
        chk("load_mixed", 32'(bif.count), 32'h1205);

`ifdef LAP_CAPTURE_EN
        // Lap snapshot on a stepping edge
        do_clear();
        do_load(16'h0041);
        mdl = 16'h0041;
        do_start();
        step_check("lap_pre", 4);
        cyc();
        cyc();
        cyc();
        bif.lap = 1'b1;
        step_check("lap_step", 1);
        bif.lap = 1'b0;
        chk("lap_value", 32'(bif.lap_count), 32'h0042);
        do_clear();
        chk("lap_clear", 32'(bif.lap_count), 32'h0);
        bif.lap = 1'b1;
        cyc();
        bif.lap = 1'b0;
        chk("lap_idle", 32'(bif.lap_count), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
